// File: rtl/ifid_skid_reg.sv
// ifid_skid_reg
//   IF/ID pipeline stage register. Carries PC+4 and the fetched instruction
//   from fetch to decode with a valid/ready handshake on both sides.
//   SKID_EN=1: two-entry skid buffer, in_ready comes straight from a register.
//   SKID_EN=0: single entry, in_ready passes out_ready through combinationally.
//   flush discards every held beat and presents a NOP bubble.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush                drop held and incoming beats
//   add4_in, inst_in     beat from fetch
//   in_valid, in_ready   fetch-side handshake
//   add4_out, inst_out   beat to decode (main register)
//   out_valid, out_ready decode-side handshake
//   count                beats held (0..2)
module ifid_skid_reg #(
  parameter int unsigned           WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0]  NOP_INST  = '0,
  parameter bit                    SKID_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] add4_in,
  input  logic [WORD_SIZE-1:0] inst_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] add4_out,
  output logic [WORD_SIZE-1:0] inst_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] main_add4, main_add4_nxt;
  logic [WORD_SIZE-1:0] main_inst, main_inst_nxt;
  logic [WORD_SIZE-1:0] skid_add4, skid_add4_nxt;
  logic [WORD_SIZE-1:0] skid_inst, skid_inst_nxt;
  logic                 accept, emit;

  assign out_valid = (state != S_EMPTY);
  assign in_ready  = SKID_EN ? (state != S_FULL) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign add4_out  = main_add4;
  assign inst_out  = main_inst;

  always_comb begin
    count = 2'd0;
    case (state)
      S_ONE:   count = 2'd1;
      S_FULL:  count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // main_inst is forced to NOP_INST on every transition into EMPTY so that
  // inst_out shows the bubble without an output mux; add4 simply holds.
  always_comb begin
    state_nxt     = state;
    main_add4_nxt = main_add4;
    main_inst_nxt = main_inst;
    skid_add4_nxt = skid_add4;
    skid_inst_nxt = skid_inst;
    if (flush) begin
      state_nxt     = S_EMPTY;
      main_inst_nxt = NOP_INST;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt     = S_ONE;
            main_add4_nxt = add4_in;
            main_inst_nxt = inst_in;
          end
        end
        S_ONE: begin
          if (accept && emit) begin
            main_add4_nxt = add4_in;
            main_inst_nxt = inst_in;
          end else if (accept && SKID_EN) begin
            state_nxt     = S_FULL;
            skid_add4_nxt = add4_in;
            skid_inst_nxt = inst_in;
          end else if (emit) begin
            state_nxt     = S_EMPTY;
            main_inst_nxt = NOP_INST;
          end
        end
        S_FULL: begin
          if (emit) begin
            state_nxt     = S_ONE;
            main_add4_nxt = skid_add4;
            main_inst_nxt = skid_inst;
          end
        end
        default: begin
          state_nxt     = S_EMPTY;
          main_inst_nxt = NOP_INST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      main_add4 <= '0;
      main_inst <= NOP_INST;
    end else begin
      state     <= state_nxt;
      main_add4 <= main_add4_nxt;
      main_inst <= main_inst_nxt;
      skid_add4 <= skid_add4_nxt;
      skid_inst <= skid_inst_nxt;
    end
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// tb_ifid_skid_reg
//   Drives one skid-enabled and one pass-through instance with the same
//   stimulus. Each instance has a queue of held beats: accepted beats are
//   pushed, emitted beats popped, and every cycle the outputs are compared
//   against the queue head.
module tb_ifid_skid_reg;

  localparam logic [31:0] NOP1 = 32'h0000_0000;
  localparam logic [31:0] NOP0 = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] add4;
    logic [31:0] inst;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] add4_in, inst_in;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] add4_out1, inst_out1, add4_out0, inst_out0;
  logic [1:0]  count1, count0;

  int vectors = 0;
  int miscompares = 0;

  beat_t       sb1[$];
  beat_t       sb0[$];
  logic [31:0] last1 = '0;
  logic [31:0] last0 = '0;

  always #5 clk = ~clk;

  ifid_skid_reg #(.WORD_SIZE(32), .NOP_INST(NOP1), .SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .add4_in(add4_in), .inst_in(inst_in),
    .in_valid(in_valid), .in_ready(in_ready1), .add4_out(add4_out1),
    .inst_out(inst_out1), .out_valid(out_valid1), .out_ready(out_ready),
    .count(count1)
  );

  ifid_skid_reg #(.WORD_SIZE(32), .NOP_INST(NOP0), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .add4_in(add4_in), .inst_in(inst_in),
    .in_valid(in_valid), .in_ready(in_ready0), .add4_out(add4_out0),
    .inst_out(inst_out0), .out_valid(out_valid0), .out_ready(out_ready),
    .count(count0)
  );

  // Reference model, skid instance: capacity 2, registered ready.
  always @(posedge clk) begin : model1
    int n;
    n = sb1.size();
    if (rst) begin
      sb1.delete();
      last1 <= '0;
    end else if (flush) begin
      sb1.delete();
    end else begin
      if (n > 0 && out_ready) void'(sb1.pop_front());
      if (in_valid && n < 2) sb1.push_back('{add4: add4_in, inst: inst_in});
      if (sb1.size() > 0) last1 <= sb1[0].add4;
    end
  end

  // Reference model, pass-through instance: capacity 1, ready follows out_ready.
  always @(posedge clk) begin : model0
    int n;
    n = sb0.size();
    if (rst) begin
      sb0.delete();
      last0 <= '0;
    end else if (flush) begin
      sb0.delete();
    end else begin
      if (n > 0 && out_ready) void'(sb0.pop_front());
      if (in_valid && (n == 0 || out_ready)) sb0.push_back('{add4: add4_in, inst: inst_in});
      if (sb0.size() > 0) last0 <= sb0[0].add4;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n1, n0;
    n1 = sb1.size();
    n0 = sb0.size();
    check("s.out_valid", 64'(out_valid1), 64'(n1 > 0));
    check("s.in_ready",  64'(in_ready1),  64'(n1 < 2));
    check("s.count",     64'(count1),     64'(n1));
    check("s.inst_out",  64'(inst_out1),  64'(n1 > 0 ? sb1[0].inst : NOP1));
    check("s.add4_out",  64'(add4_out1),  64'(n1 > 0 ? sb1[0].add4 : last1));
    check("p.out_valid", 64'(out_valid0), 64'(n0 > 0));
    check("p.in_ready",  64'(in_ready0),  64'(n0 == 0 || out_ready));
    check("p.count",     64'(count0),     64'(n0));
    check("p.inst_out",  64'(inst_out0),  64'(n0 > 0 ? sb0[0].inst : NOP0));
    check("p.add4_out",  64'(add4_out0),  64'(n0 > 0 ? sb0[0].add4 : last0));
  endtask

  // One cycle: apply inputs at negedge, then compare outputs (registered
  // state from the last posedge, comb ready against the new out_ready).
  task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] i,
                       input logic ordy, input logic fl, input logic r);
    @(negedge clk);
    in_valid  = iv;
    add4_in   = a;
    inst_in   = i;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    check_all();
  endtask

  task automatic idle(input logic ordy, input int cycles);
    for (int k = 0; k < cycles; k++) drive(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    add4_in = '0; inst_in = '0;

    // Reset then idle: all outputs at reset values.
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);

    // Streaming with decode always ready.
    drive(1'b1, 32'd4,  32'hA1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd8,  32'hA2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 32'hA3, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Decode stall fills the skid, then drains in order.
    drive(1'b1, 32'd4,  32'hB1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd8,  32'hB2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 32'hB3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 32'hB3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 32'hB3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 32'hB3, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 4);

    // Flush while full with a beat offered: everything dropped.
    drive(1'b1, 32'd20, 32'hC1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd24, 32'hC2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd16, 32'hC3, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 4);

    // Flush coinciding with an emit.
    drive(1'b1, 32'd28, 32'hD1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd32, 32'hD2, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Stall with a valid beat, then release with a continuous stream.
    drive(1'b1, 32'd36, 32'hE1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd40, 32'hE2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd40, 32'hE2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd44, 32'hE3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd48, 32'hE4, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Reset while full, then a clean stream.
    drive(1'b1, 32'd52, 32'hF1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd56, 32'hF2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd60, 32'hF3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'd64, 32'h71, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd68, 32'h72, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 60) == 0));
    end
    idle(1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
